// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier, WIDTH steps per product.
// Optional two's-complement operation when MUL_SIGNED_EN is defined.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   q;
  logic               c;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     sum;
  logic               c_sh;
  logic [WIDTH-1:0]   acc_sh;
  logic [WIDTH-1:0]   q_sh;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] res;
  logic               last;

`ifdef MUL_SIGNED_EN
  logic neg;

  // Most negative operand maps to 2^(W-1) as an unsigned magnitude.
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign res   = neg ? -{acc_sh, q_sh} : {acc_sh, q_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      neg <= 1'b0;
    end else if (state == IDLE && start) begin
      neg <= a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  assign a_mag = a;
  assign b_mag = b;
  assign res   = {acc_sh, q_sh};
`endif

  // Adder stage: {C,Acc} plus M when the current multiplier bit is set.
  assign sum = q[0] ? ({c, acc} + {1'b0, m}) : {c, acc};
  assign {c_sh, acc_sh, q_sh} = {1'b0, sum, q[WIDTH-1:1]};
  assign last = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      c       <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            m   <= a_mag;
            q   <= b_mag;
            acc <= '0;
            c   <= 1'b0;
            cnt <= CW'(WIDTH);
          end
        end
        RUN: begin
          c   <= c_sh;
          acc <= acc_sh;
          q   <= q_sh;
          cnt <= cnt - 1'b1;
          if (last) product <= res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (WIDTH=4).
// Signed vectors are added when MUL_SIGNED_EN is defined.
module tb_shift_add_multiplier;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks = 0;
  int errors = 0;
  int npulse;

  shift_add_multiplier #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] av,
                        input logic [3:0] bv, input logic [7:0] exp);
    start = 1'b1;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
    a     = '0;
    b     = '0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, 16'(busy), 16'd1);
      chk({tag, "_nodone"}, 16'(done), 16'd0);
      tick();
    end
    chk({tag, "_done"}, 16'(done), 16'd1);
    chk({tag, "_busylow"}, 16'(busy), 16'd0);
    chk({tag, "_prod"}, 16'(product), 16'(exp));
    tick();
    chk({tag, "_pulse1"}, 16'(done), 16'd0);
    chk({tag, "_hold"}, 16'(product), 16'(exp));
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_prod", 16'(product), 16'd0);
    rst = 1'b0;

    run_op("m5x3", 4'd5, 4'd3, 8'd15);
`ifdef MUL_SIGNED_EN
    run_op("mFxF", 4'hF, 4'hF, 8'h01);
`else
    run_op("mFxF", 4'hF, 4'hF, 8'hE1);
`endif
    run_op("m0xA", 4'h0, 4'hA, 8'h00);

    // start re-asserted while running must be ignored
    start = 1'b1;
    a     = 4'd2;
    b     = 4'd3;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    a     = 4'd7;
    b     = 4'd7;
    tick();
    tick();
    start = 1'b0;
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) npulse++;
    end
    chk("busy_pulses", 16'(npulse), 16'd1);
    chk("busy_prod", 16'(product), 16'd6);

    // abort in the second RUN cycle
    start = 1'b1;
    a     = 4'd9;
    b     = 4'd9;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_prod", 16'(product), 16'd0);
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) npulse++;
    end
    chk("abort_pulses", 16'(npulse), 16'd0);
    chk("abort_prod2", 16'(product), 16'd0);
    run_op("m6x7", 4'd6, 4'd7, 8'd42);

    // start held high: one result every 6 cycles
    start = 1'b1;
    a     = 4'd3;
    b     = 4'd4;
    tick();
    for (int i = 1; i <= 18; i++) begin
      tick();
      chk("b2b_done", 16'(done), 16'((i % 6) == 4));
      chk("b2b_prod", 16'(product), (i < 4) ? 16'd42 : 16'd12);
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("b2b_idle", 16'(busy), 16'd0);

`ifdef MUL_SIGNED_EN
    run_op("sDx5", 4'hD, 4'h5, 8'hF1);
    run_op("s8x8", 4'h8, 4'h8, 8'h40);
    run_op("s8x1", 4'h8, 4'h1, 8'hF8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned WIDTH x WIDTH multiplier built around a WIDTH-bit adder datapath. Each cycle it adds the multiplicand into a running partial product when the current multiplier bit is 1, then shifts right. It sits directly downstream of the ripple-carry adder: the adder's sum and carry-out feed the accumulator every cycle. It is used wherever a product is needed and WIDTH cycles of latency is acceptable.

## Interface
- WIDTH, 4, operand width in bits (≥2); product is 2*WIDTH bits
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- a  input  WIDTH  multiplicand, captured when start is accepted
- b  input  WIDTH  multiplier, captured when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when product becomes valid
- product  output  2*WIDTH  result; held stable until the next accepted start

## Operation
- Reset behaviour: synchronous active-high reset on clk. While rst is high at a clock edge, the block goes to IDLE and busy=0, done=0, product=0. All internal registers clear.
- Registers:
  - M[WIDTH-1:0]: multiplicand
  - Acc[WIDTH-1:0]: upper partial product
  - Q[WIDTH-1:0]: multiplier, shifted out LSB-first
  - C: adder carry
  - cnt: counts down from WIDTH; width is clog2(WIDTH)+1
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: M←a, Q←b, Acc←0, C←0, cnt←WIDTH, go to RUN.
  - Otherwise stay in IDLE.
- RUN, one step per cycle:
  - {C,Acc}_next = Q[0] ? Acc+M (WIDTH+1-bit result) : {0,Acc}.
  - {C,Acc,Q} ← ({C_next,Acc_next,Q} >> 1); zero-fill at the MSB.
  - cnt ← cnt-1.
  - On the step where cnt==1, product←{Acc_shifted,Q_shifted} and go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- start is ignored in RUN and DONE; no queuing. a and b are don't-care outside the accepting cycle.
- Arithmetic: no overflow is possible. The maximum (2^W-1)^2 fits in 2W bits.
- Operand zero: all WIDTH steps still execute; the latency is fixed.

## Timing
- Latency: start accepted at edge E0. Steps occur at edges E1..E_WIDTH. done and the new product are visible after edge E_WIDTH, i.e. WIDTH cycles after acceptance.
- busy is high from after E0 until E_WIDTH; it is low in the cycle done is high.
- Back-to-back operation: earliest next acceptance is the edge after the DONE cycle, giving a throughput of one result per WIDTH+2 cycles.
- Reset mid-RUN: the operation is aborted. done never pulses and product=0 the next cycle.
- product changes only at the DONE transition or on reset.

## Configuration
- MUL_SIGNED_EN defined:
  - a, b and product are two's complement.
  - At acceptance, M←|a| and Q←|b|. The magnitude is taken as unsigned WIDTH bits, so the most negative value maps to 2^(W-1).
  - neg←a[W-1]^b[W-1] is registered.
  - On the DONE transition, product←neg ? -{Acc,Q} : {Acc,Q}, all in 2W bits.
  - Latency is unchanged.
- MUL_SIGNED_EN undefined: purely unsigned; no neg register and no negation logic.

## Test plan
- Reset hold: rst=1 for 3 cycles, then start=1 with a=5, b=3 → product=8'd15, done pulses exactly 4 cycles after acceptance, busy high for 4 cycles.
- Maximum operands: a=4'hF, b=4'hF → product=8'hE1. Zero operand: a=0, b=4'hA → product=0 with full 4-cycle latency.
- Start while busy: start=1 with a=2, b=3; start re-asserted during RUN with a=7, b=7 → only 8'd6 is produced, single done pulse.
- Reset mid-operation: rst asserted in cycle 2 of RUN → no done pulse, product=0, busy=0. A subsequent a=6, b=7 → 8'd42.
- Back-to-back: hold start=1 continuously with a=3, b=4 → product=12, with done pulses every 6 cycles. product is stable between pulses.
- With MUL_SIGNED_EN:
  - a=4'hD (-3), b=5 → product=8'hF1 (-15)
  - a=4'h8, b=4'h8 → product=8'h40
  - a=4'h8, b=1 → product=8'hF8
